// File: rtl/bus_cycle_sched_if.sv
// Bus-cycle scheduler signal bundle: requests/acks, phase enables, owner and halt.
// Optional BUS_CYCLE_STATS_EN adds the stolen-cycle statistics signals.
interface bus_cycle_sched_if;
    logic        refresh_req;
    logic        dma_req;
    logic        phi0_en;
    logic        phi2_en;
    logic        phi2;
    logic [1:0]  owner;
    logic        halt_n;
    logic        refresh_ack;
    logic        dma_ack;
`ifdef BUS_CYCLE_STATS_EN
    logic        stats_clr;
    logic [15:0] stolen_cnt;

    modport master (
        input  refresh_req, dma_req, stats_clr,
        output phi0_en, phi2_en, phi2, owner, halt_n, refresh_ack, dma_ack, stolen_cnt
    );
    modport slave (
        output refresh_req, dma_req, stats_clr,
        input  phi0_en, phi2_en, phi2, owner, halt_n, refresh_ack, dma_ack, stolen_cnt
    );
`else
    modport master (
        input  refresh_req, dma_req,
        output phi0_en, phi2_en, phi2, owner, halt_n, refresh_ack, dma_ack
    );
    modport slave (
        output refresh_req, dma_req,
        input  phi0_en, phi2_en, phi2, owner, halt_n, refresh_ack, dma_ack
    );
`endif
endinterface

// File: rtl/bus_cycle_sched.sv
// Machine-cycle timebase with refresh > DMA > CPU bus arbitration at each boundary.
// Optional stolen-cycle counter enabled by defining BUS_CYCLE_STATS_EN.
module bus_cycle_sched #(
    parameter int DIV       = 16,
    parameter int MAX_STEAL = 8
) (
    input  logic               clkin,
    input  logic               RST_N,
    bus_cycle_sched_if.master  bus
);
    typedef enum logic [1:0] {
        OWN_CPU = 2'd0,
        OWN_DMA = 2'd1,
        OWN_REF = 2'd2
    } owner_e;

    localparam int              CW       = $clog2(DIV);
    localparam int              SW       = (MAX_STEAL > 0) ? $clog2(MAX_STEAL + 1) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   CNT_MID  = CW'(DIV / 2);
    localparam logic [SW-1:0]   STEAL_MAX = SW'(MAX_STEAL);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          w_boundary;
    owner_e        r_owner;
    owner_e        w_owner_nxt;
    logic [SW-1:0] r_steal_cnt;
    logic [SW-1:0] w_steal_nxt;
    logic          w_force_cpu;
    logic          r_phi0_en, r_phi2_en, r_phi2, r_halt_n;
    logic          r_refresh_ack, r_dma_ack;
    logic          w_halt_n_nxt, w_refresh_ack_nxt, w_dma_ack_nxt;

    assign w_boundary  = (r_cnt == CNT_LAST);
    assign w_cnt_nxt   = w_boundary ? '0 : r_cnt + 1'b1;
    assign w_force_cpu = (MAX_STEAL > 0) && (r_steal_cnt == STEAL_MAX);

    // Next-state: ownership and steal count only move on the DIV-1 -> 0 edge.
    always_comb begin
        // NOTE: every comb output gets a default first so no latch is inferred.
        w_owner_nxt = r_owner;
        w_steal_nxt = r_steal_cnt;
        if (w_boundary) begin
            if (w_force_cpu) begin
                w_owner_nxt = OWN_CPU;
                w_steal_nxt = '0;
            end else if (bus.refresh_req || bus.dma_req) begin
                w_owner_nxt = bus.refresh_req ? OWN_REF : OWN_DMA;
                // Below the limit here, since reaching it forces CPU first.
                if (MAX_STEAL > 0) w_steal_nxt = r_steal_cnt + 1'b1;
            end else begin
                w_owner_nxt = OWN_CPU;
                w_steal_nxt = '0;
            end
        end
    end

    always_comb begin
        w_halt_n_nxt      = (w_owner_nxt == OWN_CPU);
        w_refresh_ack_nxt = w_boundary && (w_owner_nxt == OWN_REF);
        w_dma_ack_nxt     = w_boundary && (w_owner_nxt == OWN_DMA);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clkin or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt         <= CNT_LAST;
            r_owner       <= OWN_CPU;
            r_steal_cnt   <= '0;
            r_phi0_en     <= 1'b0;
            r_phi2_en     <= 1'b0;
            r_phi2        <= 1'b0;
            r_halt_n      <= 1'b1;
            r_refresh_ack <= 1'b0;
            r_dma_ack     <= 1'b0;
        end else begin
            r_cnt         <= w_cnt_nxt;
            r_owner       <= w_owner_nxt;
            r_steal_cnt   <= w_steal_nxt;
            r_phi0_en     <= (w_cnt_nxt == '0);
            r_phi2_en     <= (w_cnt_nxt == CNT_MID);
            r_phi2        <= (w_cnt_nxt >= CNT_MID);
            r_halt_n      <= w_halt_n_nxt;
            r_refresh_ack <= w_refresh_ack_nxt;
            r_dma_ack     <= w_dma_ack_nxt;
        end
    end

    assign bus.phi0_en     = r_phi0_en;
    assign bus.phi2_en     = r_phi2_en;
    assign bus.phi2        = r_phi2;
    assign bus.owner       = r_owner;
    assign bus.halt_n      = r_halt_n;
    assign bus.refresh_ack = r_refresh_ack;
    assign bus.dma_ack     = r_dma_ack;

`ifdef BUS_CYCLE_STATS_EN
    logic [15:0] r_stolen_cnt;

    always_ff @(posedge clkin or negedge RST_N) begin
        if (!RST_N) begin
            r_stolen_cnt <= '0;
        end else if (bus.stats_clr) begin
            r_stolen_cnt <= '0;
        end else if (w_boundary && (w_owner_nxt != OWN_CPU)) begin
            r_stolen_cnt <= r_stolen_cnt + 16'd1;
        end
    end

    assign bus.stolen_cnt = r_stolen_cnt;
`endif
endmodule

// File: tb/tb_bus_cycle_sched.sv
// Directed bench for bus_cycle_sched (DIV=16, MAX_STEAL=8): vector table plus corner sequences.
// Stats checks are compiled in only when BUS_CYCLE_STATS_EN is defined.
module tb_bus_cycle_sched;
    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_cnt    = 15;

    bus_cycle_sched_if bus ();

    bus_cycle_sched #(.DIV(16), .MAX_STEAL(8)) dut (
        .clkin (clkin),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    typedef struct {
        logic       rreq;
        logic       dreq;
        logic [1:0] owner;
        logic       rack;
        logic       dack;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Sample and drive 1ns after the active edge; m_cnt tracks the expected phase.
    task automatic tick();
        @(posedge clkin);
        #1;
        m_cnt = (m_cnt == 15) ? 0 : m_cnt + 1;
    endtask

    task automatic go_to(input int c);
        while (m_cnt != c) tick();
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        go_to(5);
        bus.refresh_req = v.rreq;
        bus.dma_req     = v.dreq;
        go_to(0);
        check($sformatf("vec%0d owner", idx), 32'(bus.owner), 32'(v.owner));
        check($sformatf("vec%0d halt_n", idx), 32'(bus.halt_n), 32'(v.owner == 2'd0));
        check($sformatf("vec%0d refresh_ack", idx), 32'(bus.refresh_ack), 32'(v.rack));
        check($sformatf("vec%0d dma_ack", idx), 32'(bus.dma_ack), 32'(v.dack));
        check($sformatf("vec%0d phi0_en", idx), 32'(bus.phi0_en), 32'd1);
        tick();
        check($sformatf("vec%0d ack_pulse", idx), 32'({bus.refresh_ack, bus.dma_ack}), 32'd0);
        go_to(3);
        check($sformatf("vec%0d owner_mid", idx), 32'(bus.owner), 32'(v.owner));
    endtask

    initial begin
        int own_edges;

        vecs[0] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[2] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[7] = '{1'b1, 1'b1, 2'd2, 1'b1, 1'b0};
        vecs[8] = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1};
        vecs[9] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0};

        bus.refresh_req = 1'b0;
        bus.dma_req     = 1'b0;
`ifdef BUS_CYCLE_STATS_EN
        bus.stats_clr   = 1'b0;
`endif

        #12;
        check("rst phi0_en", 32'(bus.phi0_en), 32'd0);
        check("rst phi2_en", 32'(bus.phi2_en), 32'd0);
        check("rst phi2", 32'(bus.phi2), 32'd0);
        check("rst owner", 32'(bus.owner), 32'd0);
        check("rst halt_n", 32'(bus.halt_n), 32'd1);
        check("rst acks", 32'({bus.refresh_ack, bus.dma_ack}), 32'd0);

        @(posedge clkin);
        #1;
        rst_n = 1'b1;
        m_cnt = 15;

        // Idle timebase: phi0_en at edges 1,17,33 and phi2_en at 9,25.
        for (int k = 1; k <= 40; k++) begin
            tick();
            check($sformatf("idle%0d phi0_en", k), 32'(bus.phi0_en), 32'(k % 16 == 1));
            check($sformatf("idle%0d phi2_en", k), 32'(bus.phi2_en), 32'(k % 16 == 9));
            check($sformatf("idle%0d phi2", k), 32'(bus.phi2), 32'(((k - 1) % 16) >= 8));
            check($sformatf("idle%0d owner", k), 32'(bus.owner), 32'd0);
            check($sformatf("idle%0d halt_n", k), 32'(bus.halt_n), 32'd1);
        end

        for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

        // Request dropped before cnt==DIV-1 is never granted.
        go_to(4);
        bus.dma_req = 1'b1;
        go_to(10);
        bus.dma_req = 1'b0;
        go_to(0);
        check("drop owner", 32'(bus.owner), 32'd0);
        check("drop dma_ack", 32'(bus.dma_ack), 32'd0);

        // Late request (cnt=14) granted at the next boundary; DMA lasts exactly 16 edges.
        go_to(14);
        bus.dma_req = 1'b1;
        go_to(0);
        check("late dma_ack", 32'(bus.dma_ack), 32'd1);
        own_edges = (bus.owner == 2'd1) ? 1 : 0;
        for (int k = 0; k < 31; k++) begin
            tick();
            if (m_cnt == 1) bus.dma_req = 1'b0;
            if (bus.owner == 2'd1) own_edges++;
        end
        check("dma edge count", 32'(own_edges), 32'd16);
        check("after dma owner", 32'(bus.owner), 32'd0);

        // Continuous DMA: every 9th boundary is a forced CPU cycle with no ack.
        bus.dma_req = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            go_to(0);
            check($sformatf("steal%0d owner", k), 32'(bus.owner), (k % 9 == 0) ? 32'd0 : 32'd1);
            check($sformatf("steal%0d dma_ack", k), 32'(bus.dma_ack), (k % 9 == 0) ? 32'd0 : 32'd1);
            check($sformatf("steal%0d halt_n", k), 32'(bus.halt_n), (k % 9 == 0) ? 32'd1 : 32'd0);
        end
        tick();
        bus.dma_req = 1'b0;
        go_to(0);
        check("steal end owner", 32'(bus.owner), 32'd0);

        // Asynchronous reset in the middle of a DMA cycle.
        bus.dma_req = 1'b1;
        tick();
        go_to(0);
        check("prerst owner", 32'(bus.owner), 32'd1);
        go_to(7);
        rst_n = 1'b0;
        bus.dma_req = 1'b0;
        #1;
        check("midrst owner", 32'(bus.owner), 32'd0);
        check("midrst halt_n", 32'(bus.halt_n), 32'd1);
        check("midrst phi2", 32'(bus.phi2), 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clkin);
            #1;
            check("inrst acks", 32'({bus.refresh_ack, bus.dma_ack}), 32'd0);
            check("inrst phi0_en", 32'(bus.phi0_en), 32'd0);
        end
        rst_n = 1'b1;
        m_cnt = 15;
        tick();
        check("postrst phi0_en", 32'(bus.phi0_en), 32'd1);
        check("postrst owner", 32'(bus.owner), 32'd0);
        check("postrst halt_n", 32'(bus.halt_n), 32'd1);
        tick();
        check("postrst phi0_off", 32'(bus.phi0_en), 32'd0);

`ifdef BUS_CYCLE_STATS_EN
        go_to(5);
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        check("stats clr", 32'(bus.stolen_cnt), 32'd0);
        apply_vec('{1'b0, 1'b1, 2'd1, 1'b0, 1'b1}, 20);
        apply_vec('{1'b0, 1'b1, 2'd1, 1'b0, 1'b1}, 21);
        apply_vec('{1'b0, 1'b1, 2'd1, 1'b0, 1'b1}, 22);
        apply_vec('{1'b1, 1'b0, 2'd2, 1'b1, 1'b0}, 23);
        apply_vec('{1'b1, 1'b0, 2'd2, 1'b1, 1'b0}, 24);
        check("stats five", 32'(bus.stolen_cnt), 32'd5);
        go_to(5);
        bus.refresh_req = 1'b0;
        bus.dma_req     = 1'b1;
        go_to(15);
        bus.stats_clr = 1'b1;
        tick();
        bus.stats_clr = 1'b0;
        check("stats clr wins", 32'(bus.stolen_cnt), 32'd0);
        check("stats clr dma_ack", 32'(bus.dma_ack), 32'd1);
        tick();
        bus.dma_req = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
